vram_responder: RTL
===================

VRAM_RESPONDER -- requirements
Module: vram_responder

Interface
REQ-001 Parameter BRAM_LATENCY, default 2: BRAM read latency in clk_in cycles, legal range 1..4.
REQ-002 clk_in  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst_in  input  1  reset, synchronous and active-high.
REQ-004 tclk_in  input  1  T-cycle strobe, one clk_in cycle wide; requests SHALL be accepted only on tclk_in cycles.
REQ-005 bg_addr_in  input  16  background-fetcher byte address.
REQ-006 bg_addr_valid_in  input  1  background request; held high until bg_data_valid_out pulses.
REQ-007 bg_data_out  output  8  read data returned to the background fetcher.
REQ-008 bg_data_valid_out  output  1  one-cycle pulse qualifying bg_data_out.
REQ-009 obj_addr_in, obj_addr_valid_in, obj_data_out, obj_data_valid_out  16/1/8/1  sprite-fetcher port, same rules as REQ-005..008.
REQ-010 cpu_addr_in  input  16; cpu_wr_in  input  1; cpu_wdata_in  input  8; cpu_req_in  input  1  CPU access, held until cpu_ack_out.
REQ-011 cpu_rdata_out  output  8; cpu_ack_out  output  1  one-cycle completion pulse, read data valid with it.
REQ-012 ppu_mode_in  input  2  current PPU mode (0 HBlank, 1 VBlank, 2 OAM scan, 3 drawing).
REQ-013 bram_addr_out  output  13; bram_we_out  output  1; bram_wdata_out  output  8; bram_rdata_in  input  8  8 KiB VRAM BRAM port.
REQ-014 busy_out  output  1  high while any accepted request is still in flight.

Function
REQ-015 Each source (bg, obj, cpu) SHALL have a two-state tracker: IDLE -> PENDING on acceptance, PENDING -> IDLE on its data_valid/ack pulse; a PENDING source SHALL NOT be re-accepted.
REQ-016 On a tclk_in cycle, at most one IDLE source with its request asserted SHALL be accepted, priority obj > bg > cpu.
REQ-017 CPU requests SHALL NOT be accepted while any PPU source is requesting or PENDING.
REQ-018 CPU request in ppu_mode_in == 3: SHALL be accepted without BRAM access; reads return 8'hFF, writes are dropped.
REQ-019 Address outside 16'h8000..16'h9FFF from any source: SHALL be accepted without BRAM access; reads return 8'hFF, writes are dropped.
REQ-020 BRAM access: bram_addr_out = addr[12:0], registered in the accept cycle; bram_we_out high for exactly one cycle for accepted in-range CPU writes outside mode 3.
REQ-021 Latency: data_valid/ack SHALL pulse exactly BRAM_LATENCY+1 clk_in cycles after the accept cycle, for every request including 8'hFF and dropped-write responses.
REQ-022 Return path SHALL be a BRAM_LATENCY+1-deep shift register of {valid, source tag, force_FF}; bram_rdata_in is captured at the tail.
REQ-023 Accepts on consecutive tclk_in strobes SHALL pipeline; in-flight requests never block acceptance of a different source.
REQ-024 Data outputs SHALL hold their last returned value between pulses; cpu_rdata_out on a write ack is don't-care.
REQ-025 Deassertion of a request while PENDING SHALL NOT cancel it; the response is still delivered.
REQ-026 busy_out = OR of all PENDING flags, registered.

Reset
REQ-027 On rst_in: all trackers IDLE, return pipeline flushed, all outputs 0 (bram_addr_out 0, data outputs 8'h00, all valid/ack 0, busy_out 0).
REQ-028 Reset asserted mid-operation SHALL discard in-flight requests; no data_valid/ack pulse is emitted for them after reset.
REQ-029 Requests asserted during the reset cycle SHALL be ignored; acceptance resumes on the first tclk_in after rst_in falls.

Verification
REQ-030 BRAM preload 0x1800=8'hA5; bg read 0x9800 on tclk -> bg_data_valid_out pulse 3 cycles later with 8'hA5, busy_out high meanwhile.
REQ-031 bg 0x8000 and obj 0x8010 both raised on same tclk -> obj accepted first, bg on next tclk strobe; each returns its own preload value.
REQ-032 CPU write 0x8123=8'h3C in mode 0, then read -> ack after 3 cycles each, read returns 8'h3C; repeat in mode 3 -> read 8'hFF, BRAM unchanged.
REQ-033 bg read 0x7FFF -> 8'hFF after 3 cycles, bram_addr_out unchanged; CPU request while bg PENDING -> CPU accepted only after bg returns.
REQ-034 Obj read accepted, rst_in pulsed 1 cycle later -> no obj_data_valid_out, busy_out 0, next obj request served normally.
REQ-035 Parameter sweep BRAM_LATENCY=1 and 4 -> REQ-030 latency becomes 2 and 5 cycles respectively.

Source files
------------

// File: rtl/vram_responder.sv
// vram_responder: arbitrates bg/obj/cpu accesses onto one VRAM BRAM port with a fixed-latency return pipeline
module vram_responder #(
  parameter int BRAM_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        tclk_in,
  input  logic [15:0] bg_addr_in,
  input  logic        bg_addr_valid_in,
  output logic [7:0]  bg_data_out,
  output logic        bg_data_valid_out,
  input  logic [15:0] obj_addr_in,
  input  logic        obj_addr_valid_in,
  output logic [7:0]  obj_data_out,
  output logic        obj_data_valid_out,
  input  logic [15:0] cpu_addr_in,
  input  logic        cpu_wr_in,
  input  logic [7:0]  cpu_wdata_in,
  input  logic        cpu_req_in,
  output logic [7:0]  cpu_rdata_out,
  output logic        cpu_ack_out,
  input  logic [1:0]  ppu_mode_in,
  output logic [12:0] bram_addr_out,
  output logic        bram_we_out,
  output logic [7:0]  bram_wdata_out,
  input  logic [7:0]  bram_rdata_in,
  output logic        busy_out
);
  typedef enum logic {IDLE, PENDING} trk_t;
  typedef struct packed {
    logic       v;
    logic [1:0] src;
    logic       ff;
  } ret_t;
  localparam logic [1:0] SRC_BG = 2'd0, SRC_OBJ = 2'd1, SRC_CPU = 2'd2;
  trk_t                  trk_q [3];
  trk_t                  trk_d [3];
  ret_t [BRAM_LATENCY:0] ret_q, ret_d;
  ret_t                  tail;
  logic [12:0] bram_addr_q, bram_addr_d;
  logic        bram_we_q, bram_we_d;
  logic [7:0]  bram_wdata_q, bram_wdata_d;
  logic [7:0]  bg_data_q, bg_data_d, obj_data_q, obj_data_d, cpu_rdata_q, cpu_rdata_d;
  logic        bg_valid_q, bg_valid_d, obj_valid_q, obj_valid_d, cpu_ack_q, cpu_ack_d;
  logic        busy_q, busy_d;
  logic        obj_acc, bg_acc, cpu_acc, ppu_active, acc, acc_ff;
  logic [1:0]  acc_src;
  logic [15:0] acc_addr;
  logic [7:0]  rdata;
  always_comb begin
    obj_acc    = tclk_in && obj_addr_valid_in && trk_q[SRC_OBJ] == IDLE;
    bg_acc     = tclk_in && bg_addr_valid_in && trk_q[SRC_BG] == IDLE && !obj_acc;
    ppu_active = bg_addr_valid_in || obj_addr_valid_in || trk_q[SRC_BG] == PENDING || trk_q[SRC_OBJ] == PENDING;
    cpu_acc    = tclk_in && cpu_req_in && trk_q[SRC_CPU] == IDLE && !ppu_active;
    acc        = obj_acc || bg_acc || cpu_acc;
    acc_src    = obj_acc ? SRC_OBJ : bg_acc ? SRC_BG : SRC_CPU;
    acc_addr   = obj_acc ? obj_addr_in : bg_acc ? bg_addr_in : cpu_addr_in;
    // Out-of-window addresses and CPU accesses during drawing never touch the BRAM
    acc_ff     = acc_addr[15:13] != 3'b100 || (cpu_acc && ppu_mode_in == 2'd3);
    ret_d      = {ret_q[BRAM_LATENCY-1:0], ret_t'{v: acc, src: acc_src, ff: acc_ff}};
    tail       = ret_q[BRAM_LATENCY];
    rdata      = tail.ff ? 8'hFF : bram_rdata_in;
    bg_valid_d  = tail.v && tail.src == SRC_BG;
    obj_valid_d = tail.v && tail.src == SRC_OBJ;
    cpu_ack_d   = tail.v && tail.src == SRC_CPU;
    bg_data_d   = bg_valid_d ? rdata : bg_data_q;
    obj_data_d  = obj_valid_d ? rdata : obj_data_q;
    cpu_rdata_d = cpu_ack_d ? rdata : cpu_rdata_q;
    for (int i = 0; i < 3; i++)
      trk_d[i] = (acc && acc_src == 2'(i)) ? PENDING : (tail.v && tail.src == 2'(i)) ? IDLE : trk_q[i];
    busy_d       = trk_d[0] == PENDING || trk_d[1] == PENDING || trk_d[2] == PENDING;
    bram_addr_d  = (acc && !acc_ff) ? acc_addr[12:0] : bram_addr_q;
    bram_we_d    = cpu_acc && cpu_wr_in && !acc_ff;
    bram_wdata_d = bram_we_d ? cpu_wdata_in : bram_wdata_q;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      trk_q        <= '{default: IDLE};
      ret_q        <= '0;
      bram_addr_q  <= '0;
      bram_we_q    <= 1'b0;
      bram_wdata_q <= '0;
      bg_data_q    <= '0;
      obj_data_q   <= '0;
      cpu_rdata_q  <= '0;
      bg_valid_q   <= 1'b0;
      obj_valid_q  <= 1'b0;
      cpu_ack_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      trk_q        <= trk_d;
      ret_q        <= ret_d;
      bram_addr_q  <= bram_addr_d;
      bram_we_q    <= bram_we_d;
      bram_wdata_q <= bram_wdata_d;
      bg_data_q    <= bg_data_d;
      obj_data_q   <= obj_data_d;
      cpu_rdata_q  <= cpu_rdata_d;
      bg_valid_q   <= bg_valid_d;
      obj_valid_q  <= obj_valid_d;
      cpu_ack_q    <= cpu_ack_d;
      busy_q       <= busy_d;
    end
  end
  assign bg_data_out        = bg_data_q;
  assign bg_data_valid_out  = bg_valid_q;
  assign obj_data_out       = obj_data_q;
  assign obj_data_valid_out = obj_valid_q;
  assign cpu_rdata_out      = cpu_rdata_q;
  assign cpu_ack_out        = cpu_ack_q;
  assign bram_addr_out      = bram_addr_q;
  assign bram_we_out        = bram_we_q;
  assign bram_wdata_out     = bram_wdata_q;
  assign busy_out           = busy_q;
endmodule
